// File: rtl/edge_seq_gen.sv
// Drives one start/a/b handshake per start rise: a pulses dly cycles after the rise, then b holds HOLD cycles.
// Busy for dly+HOLD+1 cycles; there is no backpressure, and a rise while busy is flagged on err and dropped.
module edge_seq_gen #(
  parameter int DLY_W = 4,
  parameter int HOLD  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DLY_W-1:0] dly,
  output logic             a,
  output logic             b,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int HW = $clog2(HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ASSERT_A,
    S_ASSERT_B
  } state_t;

  state_t           state, state_nxt;
  logic             start_q;
  logic [DLY_W-1:0] cnt, cnt_nxt;
  logic [HW-1:0]    hcnt, hcnt_nxt;
  logic             a_nxt, b_nxt, busy_nxt, done_nxt, err_nxt;
  logic             rise;

  // start_q resets high so a start level held through reset is not seen as a rise
  assign rise = start & ~start_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      start_q <= 1'b1;
      cnt     <= '0;
      hcnt    <= '0;
      a       <= 1'b0;
      b       <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_nxt;
      start_q <= start;
      cnt     <= cnt_nxt;
      hcnt    <= hcnt_nxt;
      a       <= a_nxt;
      b       <= b_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      err     <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    hcnt_nxt  = hcnt;
    a_nxt     = a;
    b_nxt     = b;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;

    case (state)
      S_IDLE: begin
        if (rise) begin
          busy_nxt = 1'b1;
          if (dly == '0) begin
            a_nxt     = 1'b1;
            state_nxt = S_ASSERT_A;
          end else begin
            cnt_nxt   = dly - DLY_W'(1);
            state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt == '0) begin
          a_nxt     = 1'b1;
          state_nxt = S_ASSERT_A;
        end else begin
          cnt_nxt = cnt - DLY_W'(1);
        end
      end
      S_ASSERT_A: begin
        a_nxt     = 1'b0;
        b_nxt     = 1'b1;
        hcnt_nxt  = HOLD_LAST;
        state_nxt = S_ASSERT_B;
      end
      S_ASSERT_B: begin
        if (hcnt == '0) begin
          b_nxt     = 1'b0;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          hcnt_nxt = hcnt - HW'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    // A rise outside IDLE is reported but never disturbs the running sequence
    if (rise && state != S_IDLE) err_nxt = 1'b1;
  end

endmodule

// File: tb/tb_edge_seq_gen.sv
// Bench for edge_seq_gen: two instances (HOLD=4 and HOLD=1) checked against a timing-rule model.
module tb_edge_seq_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] dly;
  logic       a0, b0, busy0, done0, err0;
  logic       a1, b1, busy1, done1, err1;
  logic [4:0] obs0, obs1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  edge_seq_gen #(.DLY_W(4), .HOLD(4)) dut0 (
    .clk(clk), .rst(rst), .start(start), .dly(dly),
    .a(a0), .b(b0), .busy(busy0), .done(done0), .err(err0)
  );

  edge_seq_gen #(.DLY_W(4), .HOLD(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .dly(dly),
    .a(a1), .b(b1), .busy(busy1), .done(done1), .err(err1)
  );

  assign obs0 = {a0, b0, busy0, done0, err0};
  assign obs1 = {a1, b1, busy1, done1, err1};

  // Reference: a sequence accepted at edge E with delay D gives, at edge E+t,
  // a = (t==D), b = (D<t<=D+H), busy = (t<=D+H), done = (t==D+H+1).
  int         cyc = 0;
  bit         m_prev = 1'b1;
  bit         m_act [2];
  int         m_e [2];
  int         m_d [2];
  int         holds [2] = '{4, 1};
  logic [4:0] exp_v [2];

  always @(posedge clk) begin : model
    bit rise;
    cyc++;
    if (rst) begin
      m_prev = 1'b1;
      for (int k = 0; k < 2; k++) begin
        m_act[k] = 1'b0;
        exp_v[k] = 5'b0;
      end
    end else begin
      rise   = start && !m_prev;
      m_prev = start;
      for (int k = 0; k < 2; k++) begin : per_inst
        logic ea, eb, ebusy, edone, eerr;
        int t;
        ea = 1'b0; eb = 1'b0; ebusy = 1'b0; edone = 1'b0;
        eerr = m_act[k] && rise;
        if (!m_act[k] && rise) begin
          m_act[k] = 1'b1;
          m_e[k]   = cyc;
          m_d[k]   = int'(dly);
        end
        if (m_act[k]) begin
          t     = cyc - m_e[k];
          ea    = (t == m_d[k]);
          eb    = (t > m_d[k]) && (t <= m_d[k] + holds[k]);
          ebusy = (t <= m_d[k] + holds[k]);
          edone = (t == m_d[k] + holds[k] + 1);
          if (edone) m_act[k] = 1'b0;
        end
        exp_v[k] = {ea, eb, ebusy, edone, eerr};
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; dly = 4'd0;
    repeat (3) @(negedge clk);
    checks++;
    if ({obs0, obs1} !== 10'b0) begin
      errors++; $display("FAIL reset_state got=%b/%b exp=00000/00000", obs0, obs1);
    end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({a0, b0, busy0, a1, b1, busy1} !== 6'b0) begin
        errors++; $display("FAIL reset_held_start cyc=%0d got=%b exp=000000", cyc, {a0, b0, busy0, a1, b1, busy1});
      end
      checks++;
      if (obs0 !== exp_v[0] || obs1 !== exp_v[1]) begin
        errors++; $display("FAIL reset_model cyc=%0d got=%b/%b exp=%b/%b", cyc, obs0, obs1, exp_v[0], exp_v[1]);
      end
    end
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_dly0();
    int e, first_a, done_at, b_cnt, done_cnt;
    first_a = -1; done_at = -1; b_cnt = 0; done_cnt = 0;
    dly = 4'd0; start = 1'b1; e = cyc + 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) start = 1'b0;
      checks++;
      if (obs0 !== exp_v[0] || obs1 !== exp_v[1]) begin
        errors++; $display("FAIL dly0_model cyc=%0d got=%b/%b exp=%b/%b", cyc, obs0, obs1, exp_v[0], exp_v[1]);
      end
      if (a0 && first_a < 0) first_a = cyc;
      if (b0) b_cnt++;
      if (done0) begin done_cnt++; done_at = cyc; end
    end
    checks++;
    if (first_a !== e) begin errors++; $display("FAIL dly0_a_edge got=%0d exp=%0d", first_a, e); end
    checks++;
    if (b_cnt !== 4) begin errors++; $display("FAIL dly0_b_len got=%0d exp=4", b_cnt); end
    checks++;
    if (done_cnt !== 1 || done_at !== e + 5) begin
      errors++; $display("FAIL dly0_done got=%0d@%0d exp=1@%0d", done_cnt, done_at, e + 5);
    end
  endtask

  task automatic test_held();
    int e, first_a, b_cnt, done_cnt, err_cnt;
    first_a = -1; b_cnt = 0; done_cnt = 0; err_cnt = 0;
    dly = 4'd3; start = 1'b1; e = cyc + 1;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (i == 19) start = 1'b0;
      checks++;
      if (obs0 !== exp_v[0] || obs1 !== exp_v[1]) begin
        errors++; $display("FAIL held_model cyc=%0d got=%b/%b exp=%b/%b", cyc, obs0, obs1, exp_v[0], exp_v[1]);
      end
      if (a0 && first_a < 0) first_a = cyc;
      if (b0) b_cnt++;
      if (done0) done_cnt++;
      if (err0 || err1) err_cnt++;
    end
    checks++;
    if (first_a !== e + 3) begin errors++; $display("FAIL held_a_edge got=%0d exp=%0d", first_a, e + 3); end
    checks++;
    if (b_cnt !== 4 || done_cnt !== 1) begin
      errors++; $display("FAIL held_once got b=%0d done=%0d exp b=4 done=1", b_cnt, done_cnt);
    end
    checks++;
    if (err_cnt !== 0) begin errors++; $display("FAIL held_err got=%0d exp=0", err_cnt); end
  endtask

  task automatic test_overlap();
    int e, first_a, done_cnt, err_cnt, err_at;
    first_a = -1; done_cnt = 0; err_cnt = 0; err_at = -1;
    dly = 4'd5; start = 1'b1; e = cyc + 1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (i == 0) start = 1'b0;
      if (i == 1) start = 1'b1;
      if (i == 2) start = 1'b0;
      checks++;
      if (obs0 !== exp_v[0] || obs1 !== exp_v[1]) begin
        errors++; $display("FAIL overlap_model cyc=%0d got=%b/%b exp=%b/%b", cyc, obs0, obs1, exp_v[0], exp_v[1]);
      end
      if (a0 && first_a < 0) first_a = cyc;
      if (done0) done_cnt++;
      if (err0) begin err_cnt++; err_at = cyc; end
    end
    checks++;
    if (err_cnt !== 1 || err_at !== e + 2) begin
      errors++; $display("FAIL overlap_err got=%0d@%0d exp=1@%0d", err_cnt, err_at, e + 2);
    end
    checks++;
    if (first_a !== e + 5 || done_cnt !== 1) begin
      errors++; $display("FAIL overlap_timing got a@%0d done=%0d exp a@%0d done=1", first_a, done_cnt, e + 5);
    end
  endtask

  task automatic test_reset_mid();
    int waited, done_cnt;
    bit seen_b;
    seen_b = 1'b0; waited = 0; done_cnt = 0;
    dly = 4'($urandom_range(0, 7)); start = 1'b1;
    while (!seen_b && waited < 30) begin
      @(negedge clk);
      start = 1'b0;
      waited++;
      checks++;
      if (obs0 !== exp_v[0] || obs1 !== exp_v[1]) begin
        errors++; $display("FAIL rstmid_model cyc=%0d got=%b/%b exp=%b/%b", cyc, obs0, obs1, exp_v[0], exp_v[1]);
      end
      seen_b = b0;
    end
    checks++;
    if (!seen_b) begin errors++; $display("FAIL rstmid_wait_b got=timeout exp=b high"); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({obs0, obs1} !== 10'b0) begin
      errors++; $display("FAIL rstmid_abort got=%b/%b exp=00000/00000", obs0, obs1);
    end
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      if (i == 1) begin dly = 4'($urandom_range(0, 9)); start = 1'b1; end
      if (i == 2) start = 1'b0;
      checks++;
      if (obs0 !== exp_v[0] || obs1 !== exp_v[1]) begin
        errors++; $display("FAIL rstmid_fresh cyc=%0d got=%b/%b exp=%b/%b", cyc, obs0, obs1, exp_v[0], exp_v[1]);
      end
      if (done0) done_cnt++;
    end
    checks++;
    if (done_cnt !== 1) begin errors++; $display("FAIL rstmid_done got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_dly_max();
    int e, first_a0, first_a1, b_cnt0, b_cnt1, overlap;
    first_a0 = -1; first_a1 = -1; b_cnt0 = 0; b_cnt1 = 0; overlap = 0;
    dly = 4'd15; start = 1'b1; e = cyc + 1;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (i == 0) start = 1'b0;
      if (i == 3) dly = 4'd0;
      checks++;
      if (obs0 !== exp_v[0] || obs1 !== exp_v[1]) begin
        errors++; $display("FAIL dlymax_model cyc=%0d got=%b/%b exp=%b/%b", cyc, obs0, obs1, exp_v[0], exp_v[1]);
      end
      if (a0 && first_a0 < 0) first_a0 = cyc;
      if (a1 && first_a1 < 0) first_a1 = cyc;
      if (b0) b_cnt0++;
      if (b1) b_cnt1++;
      if ((a0 && b0) || (a1 && b1)) overlap++;
    end
    checks++;
    if (first_a0 !== e + 15 || first_a1 !== e + 15) begin
      errors++; $display("FAIL dlymax_a_edge got=%0d/%0d exp=%0d", first_a0, first_a1, e + 15);
    end
    checks++;
    if (b_cnt1 !== 1 || b_cnt0 !== 4) begin
      errors++; $display("FAIL dlymax_b_len got=%0d/%0d exp=4/1", b_cnt0, b_cnt1);
    end
    checks++;
    if (overlap !== 0) begin errors++; $display("FAIL dlymax_ab_overlap got=%0d exp=0", overlap); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      checks++;
      if (obs0 !== exp_v[0] || obs1 !== exp_v[1]) begin
        errors++; $display("FAIL random_model cyc=%0d got=%b/%b exp=%b/%b", cyc, obs0, obs1, exp_v[0], exp_v[1]);
      end
      start = ($urandom_range(0, 9) < 4);
      dly   = 4'($urandom_range(0, 15));
      rst   = ($urandom_range(0, 99) == 0);
    end
    rst = 1'b0; start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_dly0();
    test_held();
    test_overlap();
    test_reset_mid();
    test_dly_max();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
